pc_sequencer: RTL and testbench

Fetch sequencer for the MIPS PC register. Each cycle it decides whether the PC advances, redirects or holds. It computes the next-PC value from sequential, branch, jump, register-jump and exception sources, and drives the PC's `data_in` and write enable. It also runs the instruction-memory request/acknowledge handshake and a fetch timeout. It sits between the PC register, the instruction memory and the decode/branch logic.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer for the MIPS PC: chooses the next PC (sequential, branch, jump,
// register jump, exception), runs the imem request/ack handshake and the fetch timeout.
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [3:0]  TIMEOUT    = 4'd15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] epc,
  output logic [31:0] fetch_count
);

  // S_IDLE is the single dead cycle that follows an abandoned fetch
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_STALL, S_IDLE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  tcnt_reg, tcnt_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] count_reg, count_next;

  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic        redirect_err;
  logic        abandon;

  assign seq_pc    = pc_in + 32'd4;
  assign imem_addr = pc_in;
  assign abandon   = (state_reg == S_FETCH) && !imem_ack &&
                     (exception || (tcnt_reg == TIMEOUT));

  // Redirect priority on an ack: exception, misaligned jr, jr, jump, branch, sequential
  always_comb begin
    redirect_err = exception || (jr && (jr_addr[1:0] != 2'b00));
    if (redirect_err)      redirect_pc = EXC_VECTOR;
    else if (jr)           redirect_pc = jr_addr;
    else if (jump)         redirect_pc = {seq_pc[31:28], jump_target, 2'b00};
    else if (branch_taken) redirect_pc = seq_pc + (branch_offset << 2);
    else                   redirect_pc = seq_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_RESET;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)     state_next = stall ? S_STALL : S_FETCH;
        else if (abandon) state_next = S_IDLE;
      end
      S_STALL: state_next = stall ? S_STALL : S_FETCH;
      S_IDLE:  state_next = S_FETCH;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    pc_next     = seq_pc;
    pc_we       = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    epc_next    = epc_reg;
    count_next  = count_reg;
    tcnt_next   = 4'd0;
    case (state_reg)
      S_RESET: begin
        pc_we   = 1'b1;
        pc_next = RESET_ADDR;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          pc_we       = 1'b1;
          pc_next     = redirect_pc;
          count_next  = count_reg + 32'd1;
          if (redirect_err) epc_next = pc_in;
        end else if (abandon) begin
          pc_we    = 1'b1;
          pc_next  = EXC_VECTOR;
          epc_next = pc_in;
        end else begin
          tcnt_next = tcnt_reg + 4'd1;
        end
      end
      S_STALL: begin
        if (exception) begin
          pc_we    = 1'b1;
          pc_next  = EXC_VECTOR;
          epc_next = pc_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt_reg  <= 4'd0;
      epc_reg   <= 32'd0;
      count_reg <= 32'd0;
    end else begin
      tcnt_reg  <= tcnt_next;
      epc_reg   <= epc_next;
      count_reg <= count_next;
    end
  end

  assign epc         = epc_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed redirect table, hand sequences for stall/timeout/reset,
// then randomized traffic against a cycle-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in = 32'h1234_5678;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        stall;
  logic        exception;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] epc;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_next(pc_next), .pc_we(pc_we),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .stall(stall), .exception(exception),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr), .epc(epc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // the PC register the sequencer drives
  always @(posedge clk) if (pc_we) pc_in <= pc_next;

  typedef struct {
    logic [31:0] start;
    logic        exc;
    logic        jrv;
    logic [31:0] jra;
    logic        jmp;
    logic [25:0] jt;
    logic        br;
    logic [31:0] bo;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mkv(logic [31:0] start, logic exc, logic jrv, logic [31:0] jra,
                               logic jmp, logic [25:0] jt, logic br, logic [31:0] bo,
                               logic [31:0] exp_pc, logic exp_fault);
    vec_t v;
    v.start = start; v.exc = exc; v.jrv = jrv; v.jra = jra; v.jmp = jmp; v.jt = jt;
    v.br = br; v.bo = bo; v.exp_pc = exp_pc; v.exp_fault = exp_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    imem_ack = 0; stall = 0; exception = 0; branch_taken = 0; branch_offset = 0;
    jump = 0; jump_target = 0; jr = 0; jr_addr = 0;
  endtask

  // from a FETCH cycle, accept a zero-wait fetch that jr's to addr
  task automatic goto_pc(input logic [31:0] addr);
    clear_in();
    imem_ack = 1; jr = 1; jr_addr = addr;
    #4;
    tick();
    clear_in();
  endtask

  // Reference: next PC of an accepted fetch at pc, computed from the redirect rules
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic exc,
                                           input logic jrv, input logic [31:0] jra,
                                           input logic jmp, input logic [25:0] jt,
                                           input logic br, input logic [31:0] bo,
                                           output logic fault);
    logic [31:0] seq;
    seq = pc + 32'd4;
    fault = 1'b0;
    if (exc || (jrv && (jra % 4 != 0))) begin
      fault = 1'b1;
      return 32'h80;
    end
    if (jrv) return jra;
    if (jmp) return (seq & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
    if (br)  return seq + bo * 32'd4;
    return seq;
  endfunction

  // reference model state
  logic        m_rst, m_hold, m_gap;
  int          m_waited;
  logic [31:0] m_pc, m_epc, m_cnt;

  initial begin
    logic        e_req, e_we, e_valid, e_fault;
    logic [31:0] e_next, n_epc, n_cnt;
    int          ack_pct;
    int          bo_i;

    vecs[0] = mkv(32'h100, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0FC, 0);
    vecs[1] = mkv(32'h100, 0, 0, 0, 1, 26'h40, 0, 0, 32'h100, 0);
    vecs[2] = mkv(32'h100, 0, 1, 32'h2000, 0, 0, 0, 0, 32'h2000, 0);
    vecs[3] = mkv(32'h100, 0, 1, 32'h2002, 0, 0, 0, 0, 32'h080, 1);
    vecs[4] = mkv(32'h300, 1, 0, 0, 0, 0, 0, 0, 32'h080, 1);
    vecs[5] = mkv(32'h100, 1, 1, 32'h2000, 1, 26'h40, 1, 32'hFFFF_FFFE, 32'h080, 1);
    vecs[6] = mkv(32'h100, 0, 1, 32'h3000, 1, 26'h40, 1, 32'h10, 32'h3000, 0);
    vecs[7] = mkv(32'h100, 0, 0, 0, 1, 26'h55, 1, 32'h10, 32'h154, 0);
    vecs[8] = mkv(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    vecs[9] = mkv(32'hF000_0010, 0, 0, 0, 1, 26'h3FF_FFFF, 0, 0, 32'hFFFF_FFFC, 0);

    clear_in();
    reset_n = 0;
    tick(); tick();

    // reset state
    #4;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_we", 32'(pc_we), 1);
    chk("rst_next", pc_next, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_epc", epc, 0);
    chk("rst_count", fetch_count, 0);

    // zero-wait fetching from reset
    reset_n = 1; imem_ack = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      #4;
      chk("zw_addr", imem_addr, 32'(4 * i));
      chk("zw_req", 32'(imem_req), 1);
      chk("zw_valid", 32'(instr_valid), 1);
      chk("zw_next", pc_next, 32'(4 * i + 4));
      tick();
    end
    chk("zw_count", fetch_count, 8);

    // redirect table, each with a 2-cycle ack latency
    for (int v = 0; v < 10; v++) begin
      goto_pc(vecs[v].start);
      #4;
      chk($sformatf("v%0d_wait_req", v), 32'(imem_req), 1);
      chk($sformatf("v%0d_wait_addr", v), imem_addr, vecs[v].start);
      chk($sformatf("v%0d_wait_we", v), 32'(pc_we), 0);
      tick();
      imem_ack = 1; exception = vecs[v].exc; jr = vecs[v].jrv; jr_addr = vecs[v].jra;
      jump = vecs[v].jmp; jump_target = vecs[v].jt; branch_taken = vecs[v].br;
      branch_offset = vecs[v].bo;
      #4;
      chk($sformatf("v%0d_valid", v), 32'(instr_valid), 1);
      chk($sformatf("v%0d_we", v), 32'(pc_we), 1);
      chk($sformatf("v%0d_next", v), pc_next, vecs[v].exp_pc);
      tick();
      clear_in();
      #4;
      chk($sformatf("v%0d_addr", v), imem_addr, vecs[v].exp_pc);
      if (vecs[v].exp_fault) chk($sformatf("v%0d_epc", v), epc, vecs[v].start);
      tick();
    end

    // stall for 3 cycles after an ack at 0x20
    goto_pc(32'h20);
    imem_ack = 1; stall = 1;
    #4;
    chk("st_next", pc_next, 32'h24);
    tick();
    for (int s = 0; s < 3; s++) begin
      clear_in();
      stall = (s < 2); branch_taken = 1; branch_offset = 32'h40; jump = 1;
      #4;
      chk($sformatf("st%0d_req", s), 32'(imem_req), 0);
      chk($sformatf("st%0d_we", s), 32'(pc_we), 0);
      chk($sformatf("st%0d_pc", s), pc_in, 32'h24);
      tick();
    end
    clear_in();
    #4;
    chk("st_resume_req", 32'(imem_req), 1);
    chk("st_resume_addr", imem_addr, 32'h24);

    // ack never returns at 0x40: bus error in cycle 16
    goto_pc(32'h40);
    for (int c = 1; c <= 15; c++) begin
      #4;
      chk($sformatf("to_c%0d_req", c), 32'(imem_req), 1);
      chk($sformatf("to_c%0d_we", c), 32'(pc_we), 0);
      tick();
    end
    #4;
    chk("to_c16_we", 32'(pc_we), 1);
    chk("to_c16_next", pc_next, 32'h80);
    tick();
    imem_ack = 1;
    #4;
    chk("to_epc", epc, 32'h40);
    chk("to_idle_req", 32'(imem_req), 0);
    chk("to_idle_valid", 32'(instr_valid), 0);
    chk("to_idle_we", 32'(pc_we), 0);
    tick();
    imem_ack = 0;
    #4;
    chk("to_refetch_req", 32'(imem_req), 1);
    chk("to_refetch_addr", imem_addr, 32'h80);

    // reset in the middle of a pending fetch
    tick(); tick();
    reset_n = 0;
    #4;
    tick();
    reset_n = 1;
    #4;
    chk("rw_req", 32'(imem_req), 0);
    chk("rw_we", 32'(pc_we), 1);
    chk("rw_next", pc_next, 32'h0);
    tick();
    #4;
    chk("rw_addr", imem_addr, 32'h0);
    chk("rw_req2", 32'(imem_req), 1);
    chk("rw_count", fetch_count, 0);
    chk("rw_epc", epc, 0);

    // randomized traffic; DUT now in its first fetch cycle at PC 0
    m_rst = 0; m_hold = 0; m_gap = 0; m_waited = 0;
    m_pc = 0; m_epc = 0; m_cnt = 0;
    ack_pct = 50;
    tick();
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 50;
          2: ack_pct = 100;
          default: ack_pct = 20;
        endcase
      end
      reset_n      = ($urandom_range(0, 199) != 0);
      imem_ack     = ($urandom_range(1, 100) <= ack_pct);
      exception    = ($urandom_range(0, 19) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      jr           = ($urandom_range(0, 7) == 0);
      jr_addr      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      jump         = ($urandom_range(0, 7) == 0);
      jump_target  = 26'($urandom);
      branch_taken = ($urandom_range(0, 3) == 0);
      bo_i         = int'($urandom_range(0, 64)) - 32;
      branch_offset = 32'(bo_i);
      #4;

      e_req = 0; e_we = 0; e_valid = 0; e_next = 0; e_fault = 0;
      if (m_rst) begin
        e_we = 1; e_next = 32'h0;
      end else if (m_gap) begin
        e_we = 0;
      end else if (m_hold) begin
        if (exception) begin e_we = 1; e_next = 32'h80; end
      end else begin
        e_req = 1;
        if (imem_ack) begin
          e_valid = 1; e_we = 1;
          e_next = ref_next(m_pc, exception, jr, jr_addr, jump, jump_target,
                            branch_taken, branch_offset, e_fault);
        end else if (exception || m_waited == 15) begin
          e_we = 1; e_next = 32'h80;
        end
      end

      chk("rnd_req", 32'(imem_req), 32'(e_req));
      chk("rnd_valid", 32'(instr_valid), 32'(e_valid));
      chk("rnd_we", 32'(pc_we), 32'(e_we));
      if (e_req) chk("rnd_addr", imem_addr, m_pc);
      if (e_we)  chk("rnd_next", pc_next, e_next);
      chk("rnd_epc", epc, m_epc);
      chk("rnd_count", fetch_count, m_cnt);

      n_epc = m_epc; n_cnt = m_cnt;
      if (!m_rst && !m_gap) begin
        if (m_hold) begin
          if (exception) n_epc = m_pc;
        end else if (imem_ack) begin
          n_cnt = m_cnt + 1;
          if (e_fault) n_epc = m_pc;
        end else if (e_we) begin
          n_epc = m_pc;
        end
      end
      if (e_we) m_pc = e_next;
      if (!reset_n) begin
        m_rst = 1; m_hold = 0; m_gap = 0; m_waited = 0; n_epc = 0; n_cnt = 0;
      end else if (m_rst) m_rst = 0;
      else if (m_gap) m_gap = 0;
      else if (m_hold) m_hold = stall;
      else if (imem_ack) begin m_hold = stall; m_waited = 0; end
      else if (e_we) begin m_gap = 1; m_waited = 0; end
      else m_waited++;
      m_epc = n_epc; m_cnt = n_cnt;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
